// File: rtl/ram_bus_master_if.sv
// Client-side request/response port of ram_bus_master.
// The master modport is the ram_bus_master side; the slave modport is the requesting client.
interface ram_bus_master_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_bus_master.sv
// Sequences single read, write and indirect-read requests onto a chip-select RAM bus.
// Bus strobes and address are registered; the data-bus drive is decoded from state.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_bus_master_if.master      client,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, PTR, TGT, DONE} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_IND   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t                state_reg, state_next;
  logic [1:0]            op_reg, op_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  cs_reg, cs_next;
  logic                  we_reg, we_next;
  logic                  oe_reg, oe_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= OP_READ;
      wdata_reg <= '0;
      rdata_reg <= '0;
      addr_reg  <= '0;
      cs_reg    <= 1'b0;
      we_reg    <= 1'b0;
      oe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      addr_reg  <= addr_next;
      cs_reg    <= cs_next;
      we_reg    <= we_next;
      oe_reg    <= oe_next;
    end
  end

  // Strobes are computed for the state being entered so they leave the flops clean.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    addr_next  = addr_reg;
    cs_next    = 1'b0;
    we_next    = 1'b0;
    oe_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (client.req_valid) begin
          op_next    = client.req_op;
          wdata_next = client.req_wdata;
          case (client.req_op)
            OP_READ: begin
              state_next = READ;
              addr_next  = client.req_addr;
              cs_next    = 1'b1;
              oe_next    = 1'b1;
            end
            OP_WRITE: begin
              state_next = WRITE;
              addr_next  = client.req_addr;
              cs_next    = 1'b1;
              we_next    = 1'b1;
            end
            OP_IND: begin
              state_next = PTR;
              addr_next  = client.req_addr;
              cs_next    = 1'b1;
              oe_next    = 1'b1;
            end
            default: state_next = DONE;
          endcase
        end
      end
      WRITE: state_next = DONE;
      READ: begin
        rdata_next = mem_data;
        state_next = DONE;
      end
      PTR: begin
        // Pointer is one data byte, zero-extended onto the address bus.
        addr_next  = ADDR_WIDTH'(mem_data);
        cs_next    = 1'b1;
        oe_next    = 1'b1;
        state_next = TGT;
      end
      TGT: begin
        rdata_next = mem_data;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = addr_reg;
  assign mem_cs   = cs_reg;
  assign mem_we   = we_reg;
  assign mem_oe   = oe_reg;
  assign mem_data = (state_reg == WRITE) ? wdata_reg : {DATA_WIDTH{1'bz}};

  assign client.req_ready = (state_reg == IDLE) && !rst;
  assign client.rsp_valid = (state_reg == DONE);
  assign client.rsp_err   = (state_reg == DONE) && (op_reg == OP_RSVD);
  assign client.rsp_rdata = rdata_reg;
endmodule

// File: tb/tb_ram_bus_master.sv
// Random and directed stimulus for ram_bus_master against a transaction-level reference
// model; a bus probe drives a random pattern whenever nobody should own mem_data.
module tb_ram_bus_master;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .client   (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe)
  );

  // RAM device contents and the reference model's own copy of them.
  logic [DW-1:0] ram     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  logic [DW-1:0] probe_pat;

  wire          ram_en   = mem_cs & mem_oe & ~mem_we;
  wire          probe_en = ~mem_we & ~ram_en;
  wire [DW-1:0] ram_out  = ram[mem_addr];
  assign mem_data = ram_en   ? ram_out   : {DW{1'bz}};
  assign mem_data = probe_en ? probe_pat : {DW{1'bz}};

  typedef struct packed {
    logic          cs, we, oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rv, err, upd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, acc_cyc = 0, rsp_cyc = 0, txn = 0;
  int            rsp_cnt = 0, we_cnt = 0, oe_cnt = 0, cs_cnt = 0;
  logic [DW-1:0] m_rdata = '0, last_rdata = '0;
  logic          last_err = 1'b0;
  logic [AW-1:0] addr_log[$];
  bit            model_idle = 1'b0, acc_flag = 1'b0, wr_pend = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mid-cycle: compare DUT against the expectation for this cycle, record observations.
  task automatic check_cycle();
    exp_t e;
    bit   busy;
    busy = (q.size() != 0);
    e    = '0;
    if (busy) e = q.pop_front();
    if (e.upd) m_rdata = e.rdata;
    chk("req_ready", bus.req_ready, !busy && !rst);
    chk("mem_cs", mem_cs, e.cs);
    chk("mem_we", mem_we, e.we);
    chk("mem_oe", mem_oe, e.oe);
    chk("rsp_valid", bus.rsp_valid, e.rv);
    chk("rsp_err", bus.rsp_err, e.err);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    if (e.cs) chk("mem_addr", mem_addr, e.addr);
    if (e.we || e.oe) chk("mem_data", mem_data, e.data);
    else              chk("mem_data released", mem_data, probe_pat);
    if (mem_we) we_cnt++;
    if (mem_oe) oe_cnt++;
    if (mem_cs) begin
      cs_cnt++;
      addr_log.push_back(mem_addr);
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      txn++;
      rsp_cyc    = cyc;
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
      $display("txn %0d: rsp rdata=0x%02h err=%0b cycle %0d", txn, bus.rsp_rdata, bus.rsp_err, cyc);
    end
    wr_pend    = mem_cs && mem_we;
    wr_addr    = mem_addr;
    wr_data    = mem_data;
    model_idle = !busy;
  endtask

  // Clock edge: RAM commit (indirect-write), reset, and request acceptance.
  task automatic model_edge();
    exp_t          e0, e1, e2;
    logic [AW-1:0] a, p;
    logic [DW-1:0] d;
    cyc++;
    if (wr_pend) ram[AW'(ram[wr_addr])] = wr_data;
    wr_pend   = 1'b0;
    probe_pat = DW'($urandom);
    acc_flag  = 1'b0;
    if (rst) begin
      q.delete();
      m_rdata = '0;
    end else if (bus.req_valid && model_idle) begin
      acc_flag = 1'b1;
      acc_cyc  = cyc;
      a  = bus.req_addr;
      d  = bus.req_wdata;
      e0 = '0;
      e1 = '0;
      e2 = '0;
      case (bus.req_op)
        2'b00: begin
          e0.cs = 1'b1; e0.oe = 1'b1; e0.addr = a; e0.data = ref_mem[a];
          e1.rv = 1'b1; e1.upd = 1'b1; e1.rdata = ref_mem[a];
          q.push_back(e0); q.push_back(e1);
        end
        2'b01: begin
          e0.cs = 1'b1; e0.we = 1'b1; e0.addr = a; e0.data = d;
          e1.rv = 1'b1;
          q.push_back(e0); q.push_back(e1);
          ref_mem[AW'(ref_mem[a])] = d;
        end
        2'b10: begin
          p = AW'(ref_mem[a]);
          e0.cs = 1'b1; e0.oe = 1'b1; e0.addr = a; e0.data = ref_mem[a];
          e1.cs = 1'b1; e1.oe = 1'b1; e1.addr = p; e1.data = ref_mem[p];
          e2.rv = 1'b1; e2.upd = 1'b1; e2.rdata = ref_mem[p];
          q.push_back(e0); q.push_back(e1); q.push_back(e2);
        end
        default: begin
          e0.rv = 1'b1; e0.err = 1'b1;
          q.push_back(e0);
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit hold);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    acc_flag      = 1'b0;
    for (int t = 0; t < 16 && !acc_flag; t++) tick();
    if (!acc_flag) begin
      n_bad++;
      $display("FAIL accept: request op=%0d not taken within 16 cycles", op);
    end
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = DW'($urandom);
    end
  endtask

  initial begin
    int n0, a0, a1, a2, r;
    logic [1:0] op;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    probe_pat     = 8'h3C;
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16]     = 8'h20;
    ref_mem[16] = 8'h20;

    @(posedge clk);
    #1;
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // Write through the RAM's indirection: mem[mem[0x10]] = mem[0x20].
    we_cnt = 0;
    issue(2'b01, 13'h0010, 8'h5A, 1'b0);
    idle(3);
    chk("write we cycles", we_cnt, 1);
    chk("write mem[0x20]", ram[32], 8'h5A);
    chk("write mem[0x10]", ram[16], 8'h20);
    chk("write rsp offset", rsp_cyc - acc_cyc, 1);
    chk("write rsp err", last_err, 0);

    oe_cnt = 0;
    issue(2'b00, 13'h0020, 8'h00, 1'b0);
    idle(3);
    chk("read rdata", last_rdata, 8'h5A);
    chk("read rsp offset", rsp_cyc - acc_cyc, 1);
    chk("read oe cycles", oe_cnt, 1);

    addr_log.delete();
    issue(2'b10, 13'h0010, 8'h00, 1'b0);
    idle(4);
    chk("ind addr count", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("ind addr 0", addr_log[0], 13'h0010);
      chk("ind addr 1", addr_log[1], 13'h0020);
    end
    chk("ind rdata", last_rdata, 8'h5A);
    chk("ind rsp offset", rsp_cyc - acc_cyc, 2);

    cs_cnt = 0;
    issue(2'b11, 13'h0055, 8'h00, 1'b0);
    idle(3);
    chk("rsvd err", last_err, 1);
    chk("rsvd rsp offset", rsp_cyc - acc_cyc, 0);
    chk("rsvd cs cycles", cs_cnt, 0);
    chk("rsvd rdata held", last_rdata, 8'h5A);

    // req_valid held high across read, write, read.
    n0 = rsp_cnt;
    issue(2'b00, 13'h0020, 8'h00, 1'b1);
    a0 = acc_cyc;
    issue(2'b01, 13'h0010, 8'hC3, 1'b1);
    a1 = acc_cyc;
    issue(2'b00, 13'h0020, 8'h00, 1'b0);
    a2 = acc_cyc;
    idle(4);
    chk("b2b gap 1", a1 - a0, 3);
    chk("b2b gap 2", a2 - a1, 3);
    chk("b2b rsp count", rsp_cnt - n0, 3);
    chk("b2b last rdata", last_rdata, 8'hC3);

    // Reset lands while the indirect read is in its target cycle.
    n0 = rsp_cnt;
    issue(2'b10, 13'h0010, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    chk("rst aborted rsp count", rsp_cnt - n0, 0);
    issue(2'b00, 13'h0020, 8'h00, 1'b0);
    idle(3);
    chk("post-rst read rdata", last_rdata, 8'hC3);

    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      issue(op, AW'($urandom), DW'($urandom), bit'($urandom_range(0, 1)));
      if (!bus.req_valid) idle($urandom_range(0, 2));
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
